serial_add_sub: RTL and testbench

//   Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands CHUNK bits per

---
 rtl/serial_add_sub_if.sv | 27 ++
 rtl/serial_add_sub.sv | 80 ++++++++
 tb/tb_serial_add_sub.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// master = operand source + result sink, slave = the adder.
interface serial_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle add/sub: CHUNK bits per clock, LSB chunk first, carry held in a register.
// Flags carry-out (sub: 1 = no borrow) and signed overflow on the final chunk.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_sub_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, last, msb_cin;
    logic [CHUNK:0]   csum;

    assign csum    = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // carry into the chunk's top bit, recovered from the sum bit
    assign msb_cin = x_q[CHUNK-1] ^ y_q[CHUNK-1] ^ csum[CHUNK-1];
    assign last    = (cnt_q == CW'(NCH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            // subtract is X + ~Y + !borrow
            x_q     <= bus.x;
            y_q     <= bus.sub ? ~bus.y : bus.y;
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[cnt_q*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
            carry_q <= csum[CHUNK];
            x_q     <= x_q >> CHUNK;
            y_q     <= y_q >> CHUNK;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                cout_q <= csum[CHUNK];
                ovf_q  <= msb_cin ^ csum[CHUNK];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Runs CHUNK=4, CHUNK=1 and CHUNK=16 instances in lockstep on shared stimulus,
// checking each against an arithmetic reference model and its own latency.
module tb_serial_add_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sub, cin, out_ready;
    logic [15:0] x, y;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(16)) if4  ();
    serial_add_sub_if #(.WIDTH(16)) if1  ();
    serial_add_sub_if #(.WIDTH(16)) if16 ();

    assign if4.in_valid = in_valid;   assign if1.in_valid = in_valid;   assign if16.in_valid = in_valid;
    assign if4.x = x;                 assign if1.x = x;                 assign if16.x = x;
    assign if4.y = y;                 assign if1.y = y;                 assign if16.y = y;
    assign if4.sub = sub;             assign if1.sub = sub;             assign if16.sub = sub;
    assign if4.cin = cin;             assign if1.cin = cin;             assign if16.cin = cin;
    assign if4.out_ready = out_ready; assign if1.out_ready = out_ready; assign if16.out_ready = out_ready;

    serial_add_sub #(.WIDTH(16), .CHUNK(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_add_sub #(.WIDTH(16), .CHUNK(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_add_sub #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
        int          r;
        logic [15:0] sm;
        logic        co, ov;
        if (!s) begin
            r  = int'(a) + int'(b) + int'(c);
            sm = r[15:0];
            co = (r > 65535);
            ov = (a[15] == b[15]) && (sm[15] != a[15]);
        end else begin
            r  = int'(a) - int'(b) - int'(c);
            sm = r[15:0];
            co = (int'(a) >= int'(b) + int'(c));
            ov = (a[15] != b[15]) && (sm[15] != a[15]);
        end
        return {ov, co, sm};
    endfunction

    logic [17:0] exp_r;

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ov"},  {if4.out_valid, if1.out_valid, if16.out_valid}, 3'b000);
        chk({tag, "_rdy"}, {if4.in_ready, if1.in_ready, if16.in_ready}, 3'b111);
        chk({tag, "_sum4"}, if4.sum, 0);
        chk({tag, "_sum1"}, if1.sum, 0);
        chk({tag, "_sum16"}, if16.sum, 0);
        chk({tag, "_flags"}, {if4.cout, if4.ovf, if1.cout, if1.ovf, if16.cout, if16.ovf}, 0);
    endtask

    // Accept one operation, measure each instance's latency, check results; leaves all in DONE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c);
        int l4 = 0, l1 = 0, l16 = 0;
        logic busy_rdy = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_pre"}, {if4.in_ready, if1.in_ready, if16.in_ready}, 3'b111);
        x = a; y = b; sub = s; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        // source only holds operands until the accept edge
        in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (if4.out_valid  && l4  == 0) l4  = e;
            if (if1.out_valid  && l1  == 0) l1  = e;
            if (if16.out_valid && l16 == 0) l16 = e;
            busy_rdy |= if4.in_ready | if1.in_ready | if16.in_ready;
            if (l4 != 0 && l1 != 0 && l16 != 0) break;
        end
        chk({tag, "_lat4"},  l4, 4);
        chk({tag, "_lat1"},  l1, 16);
        chk({tag, "_lat16"}, l16, 1);
        chk({tag, "_rdy_busy"}, busy_rdy, 1'b0);
        exp_r = model(a, b, s, c);
        chk({tag, "_c4"},  {if4.ovf,  if4.cout,  if4.sum},  exp_r);
        chk({tag, "_c1"},  {if1.ovf,  if1.cout,  if1.sum},  exp_r);
        chk({tag, "_c16"}, {if16.ovf, if16.cout, if16.sum}, exp_r);
    endtask

    // Hold the sink off for some cycles (optionally with a competing request), then take the result.
    task automatic release_op(input string tag, input int hold, input bit noise);
        logic stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (noise) begin
                in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            if ({if4.ovf, if4.cout, if4.sum} !== exp_r || {if1.ovf, if1.cout, if1.sum} !== exp_r ||
                {if16.ovf, if16.cout, if16.sum} !== exp_r ||
                {if4.out_valid, if1.out_valid, if16.out_valid} !== 3'b111 ||
                {if4.in_ready, if1.in_ready, if16.in_ready} !== 3'b000)
                stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold"}, stable, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, "_ov_off"}, {if4.out_valid, if1.out_valid, if16.out_valid}, 3'b000);
        chk({tag, "_rdy_back"}, {if4.in_ready, if1.in_ready, if16.in_ready}, 3'b111);
    endtask

    typedef struct { logic [15:0] a, b; logic s, c; } op_t;
    op_t dir [6] = '{
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0}, '{16'h7FFF, 16'h0001, 1'b0, 1'b0},
        '{16'h0001, 16'h0001, 1'b0, 1'b1}, '{16'h0005, 16'h0007, 1'b1, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 1'b0}, '{16'h0010, 16'h0001, 1'b1, 1'b1}
    };

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_idle_reset("por");
        @(negedge clk) rst_n = 1'b1;

        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        chk("add_basic_sum", if4.sum, 16'h2233);
        // asynchronous reset mid-clock while results are held
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk_idle_reset("async_rst");
        @(negedge clk) rst_n = 1'b1;

        foreach (dir[i]) begin
            run_op($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].s, dir[i].c);
            release_op($sformatf("dir%0d", i), 0, 1'b0);
        end
        chk("dir_ovf_case", {dir[1].a + dir[1].b}, 16'h8000);

        run_op("bp", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
        release_op("bp", 3, 1'b1);
        run_op("bp_next", 16'h1111, 16'h2222, 1'b1, 1'b0);
        release_op("bp_next", 0, 1'b0);

        // reset during the second RUN cycle abandons the operation
        @(negedge clk);
        x = 16'h4321; y = 16'h1234; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk_idle_reset("run_rst");
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen |= if4.out_valid | if1.out_valid | if16.out_valid;
        end
        chk("run_rst_no_valid", seen, 1'b0);
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0);
        chk("after_rst_sum", if4.sum, 16'h0100);
        release_op("after_rst", 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            release_op($sformatf("rnd%0d", i), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
